regfile_sb: RTL

//   Parametrised register file for the CPU datapath, successor to the fixed 32x32 2-read/1-write regfile.

---
 rtl/regfile_sb.sv | 73 +++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file with a per-register busy scoreboard.
// Reads are combinational. An optional write-to-read bypass forwards the
// writeback value, and an optional hardwired zero register is supported.
// The scoreboard tracks pending writers so that decode can detect RAW hazards.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_wa,
  input  logic                       flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wa_zero;
  logic              w_wr_ok;

  // Writes aimed at the hardwired zero register are discarded.
  assign w_wa_zero = (ZERO_REG != 0) && (wa == '0);
  assign w_wr_ok   = we && !w_wa_zero;

  // Register storage: cleared asynchronously, written on the writeback edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wa] <= wd;
    end
  end

  // Scoreboard next state: flush wins, then issue (newer producer), then writeback clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (flush)                                   w_busy_nxt[r] = 1'b0;
      else if (iss_valid && iss_wa == ADDR_W'(r))  w_busy_nxt[r] = 1'b1;
      else if (we && wa == ADDR_W'(r))             w_busy_nxt[r] = 1'b0;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Read ports: forwarding is suppressed in reset so every output reads zero.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;
    assign w_ra  = ra[k*ADDR_W +: ADDR_W];
    assign w_hit = (BYPASS != 0) && rst_n && we && (wa == w_ra) && !w_wa_zero;
    assign rd[k*DATA_W +: DATA_W] = w_hit ? wd : r_mem[w_ra];
    assign rd_busy[k]             = r_busy[w_ra] & ~w_hit;
  end

endmodule
